shift_mem_2504_cell: RTL and testbench



---
 rtl/shift_mem_2504_cell.sv | 86 ++++++++
 tb/tb_shift_mem_2504_cell.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_mem_2504_cell.sv
// 2504-style recirculating serial storage cell (WIDTH lanes x DEPTH bits) for the
// Apple-1 video terminal, plus its 3-input AND and 2-wide AND-OR-INVERT glue gates.
module shift_mem_2504_cell #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             mr_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] si,
    output logic [WIDTH-1:0] so,
    input  logic [2:0]       a3_in,
    output logic             a3_y,
    input  logic             aoi_a,
    input  logic             aoi_b,
    input  logic             aoi_c,
    input  logic             aoi_d,
    output logic             aoi_y
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // One word per shift position; each lane owns one bit of the word.
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr;
    logic             primed_reg;
    logic             primed_next;
    logic             rd_valid;
    logic             valid_reg;
    logic             valid_next;
    logic             do_shift;

    assign do_shift = shift_en & mr_n;

    // The slot just ahead of the write pointer holds the bit written DEPTH-1
    // shift events ago, which is exactly what the last flop stage would show.
    // Until the pointer has once reached the top slot, that entry predates
    // reset and must read as zero.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        primed_next = primed_reg;
        valid_next  = valid_reg;
        rd_ptr      = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
        rd_valid    = primed_reg | (wr_ptr_reg == LAST_PTR);
        if (do_shift) begin
            wr_ptr_next = rd_ptr;
            primed_next = rd_valid;
            valid_next  = rd_valid;
        end
    end

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            wr_ptr_reg <= '0;
            primed_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            primed_reg <= primed_next;
            valid_reg  <= valid_next;
        end
    end

    // Storage array and its registered read port carry no reset so they map
    // onto block RAM; valid_reg masks stale contents after a reset.
    always_ff @(posedge clk) begin
        if (do_shift) begin
            ram[wr_ptr_reg] <= si;
            rd_data_reg     <= ram[rd_ptr];
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign so[gi] = valid_reg & rd_data_reg[gi];
        end
    endgenerate

    assign a3_y  = a3_in[0] & a3_in[1] & a3_in[2];
    assign aoi_y = ~((aoi_a & aoi_b) | (aoi_c & aoi_d));

endmodule

// File: tb/tb_shift_mem_2504_cell.sv
// Scoreboard bench for shift_mem_2504_cell: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_shift_mem_2504_cell;
    localparam int DEPTH = 1024;
    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             mr_n = 1'b0;
    logic             shift_en = 1'b0;
    logic [WIDTH-1:0] si = '0;
    logic [WIDTH-1:0] so;
    logic [2:0]       a3_in = 3'b000;
    logic             a3_y;
    logic             aoi_a = 1'b0;
    logic             aoi_b = 1'b0;
    logic             aoi_c = 1'b0;
    logic             aoi_d = 1'b0;
    logic             aoi_y;

    shift_mem_2504_cell #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .mr_n     (mr_n),
        .shift_en (shift_en),
        .si       (si),
        .so       (so),
        .a3_in    (a3_in),
        .a3_y     (a3_y),
        .aoi_a    (aoi_a),
        .aoi_b    (aoi_b),
        .aoi_c    (aoi_c),
        .aoi_d    (aoi_d),
        .aoi_y    (aoi_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] so;
        logic             a3;
        logic             aoi;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    txn = 0;
    string phase = "init";

    // a3_y truth table: only 3'b111 gives 1.
    function automatic logic a3_ref(input logic [2:0] v);
        logic [7:0] tbl;
        tbl = 8'h80;
        return tbl[v];
    endfunction

    // aoi_y truth table indexed by {a,b,c,d}: 1 for 0,1,2,4,5,6,8,9,10.
    function automatic logic aoi_ref(input logic [3:0] v);
        logic [15:0] tbl;
        tbl = 16'h0777;
        return tbl[v];
    endfunction

    function automatic logic [WIDTH-1:0] pat(input int i);
        case (i)
            0:       return 6'h2A;
            1:       return 6'h15;
            2:       return 6'h3F;
            default: return 6'((i * 37) & 63);
        endcase
    endfunction

    // One clock: drive inputs, let the edge happen, queue what so/gates must show.
    task automatic step(input logic en, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_so);
        exp_t e;
        shift_en = en;
        si       = d;
        @(posedge clk);
        e.so  = exp_so;
        e.a3  = a3_ref(a3_in);
        e.aoi = aoi_ref({aoi_a, aoi_b, aoi_c, aoi_d});
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            total += 3;
            if (so !== e.so) begin
                bad++;
                $display("FAIL %s.so txn=%0d got=%h want=%h", phase, txn, so, e.so);
            end
            if (a3_y !== e.a3) begin
                bad++;
                $display("FAIL %s.a3_y txn=%0d a3_in=%b got=%b want=%b", phase, txn, a3_in, a3_y, e.a3);
            end
            if (aoi_y !== e.aoi) begin
                bad++;
                $display("FAIL %s.aoi_y txn=%0d abcd=%b%b%b%b got=%b want=%b",
                         phase, txn, aoi_a, aoi_b, aoi_c, aoi_d, aoi_y, e.aoi);
            end
            $display("[%0t] %s txn=%0d so=%h a3_y=%b aoi_y=%b", $time, phase, txn, so, a3_y, aoi_y);
        end
    end

    initial begin
        // Reset held low: shifting ones must never reach so; a3 sweep rides along.
        phase = "reset";
        mr_n  = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            a3_in = 3'(i);
            step(1'b1, 6'h3F, 6'h00);
        end

        // AOI sweep, toggling mr_n to show the gates ignore it.
        phase = "gates";
        a3_in = 3'b000;
        for (int v = 0; v < 16; v++) begin
            {aoi_a, aoi_b, aoi_c, aoi_d} = 4'(v);
            mr_n = v[0];
            step(1'b0, 6'h00, 6'h00);
        end
        {aoi_a, aoi_b, aoi_c, aoi_d} = 4'b0000;
        mr_n = 1'b0;
        step(1'b1, 6'h3F, 6'h00);

        // A single 1 in every lane must appear exactly after the 1024th shift,
        // with a 50-cycle hold inserted midway that must not move it.
        phase = "single";
        mr_n  = 1'b1;
        step(1'b1, 6'h3F, 6'h00);
        for (int n = 2; n <= 1030; n++) begin
            if (n == 301) begin
                for (int h = 0; h < 50; h++) step(1'b0, 6'h3F, 6'h00);
            end
            step(1'b1, 6'h00, (n == DEPTH) ? 6'h3F : 6'h00);
        end

        // Fresh load of a 1024-word pattern; first word surfaces on shift 1024.
        phase = "load";
        mr_n  = 1'b0;
        #1;
        mr_n  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, pat(i), (i == DEPTH - 1) ? pat(0) : 6'h00);
        end

        // si tied to so: the pattern must come round again, and keep rotating.
        phase = "recirc";
        for (int j = 1; j <= DEPTH + 500; j++) begin
            step(1'b1, so, pat(j % DEPTH));
        end

        // Reset pulse between edges must clear so at once and wipe all content.
        phase = "areset";
        #1;
        mr_n = 1'b0;
        #1;
        total++;
        if (so !== 6'h00) begin
            bad++;
            $display("FAIL areset.immediate got=%h want=00", so);
        end
        #1;
        mr_n = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            step(1'b1, so, 6'h00);
        end

        phase = "drain";
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain.queue got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog.timeout got=%0t want<200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
